// File: rtl/uart_pkg.sv
// Shared UART state encoding and oversampling constants (rx and tx sides).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } uart_state_e;

    localparam int OS_TICKS = 16;
    localparam int MID_TICK = 7;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running mod-DVSR counter producing the 16x oversample tick.
module uart_baud_gen #(
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                s_tick,
    output logic [DVSR_BIT-1:0] count
);

    localparam logic [DVSR_BIT-1:0] LAST = DVSR_BIT'(DVSR - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign s_tick = (count == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with break hold-off.
// Optional even parity check enabled by UART_RX_PARITY_EN.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            busy
);

    localparam int SMAX = (SB_TICK > OS_TICKS) ? SB_TICK : OS_TICKS;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    uart_state_e     state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic [DBIT-1:0] dout_n;
    logic            ferr_n;
    logic            done_n;
    logic            rx_q1, rx_s;
    logic            s_tick;
`ifdef UART_RX_PARITY_EN
    logic            par, par_n;
    logic            perr_n;
`endif

    uart_baud_gen #(
        .DVSR     (DVSR),
        .DVSR_BIT (DVSR_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick),
        .count  ()
    );

    // Two-flop synchronizer; idle-high so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par          <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            dout         <= dout_n;
            frame_err    <= ferr_n;
            rx_done_tick <= done_n;
`ifdef UART_RX_PARITY_EN
            par          <= par_n;
            parity_err   <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        dout_n  = dout;
        ferr_n  = frame_err;
        done_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par;
        perr_n  = parity_err;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == SW'(MID_TICK)) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == SW'(OS_TICKS - 1)) begin
                        s_n = '0;
                        b_n = {rx_s, b[DBIT-1:1]};
                        if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == SW'(OS_TICKS - 1)) begin
                        par_n   = rx_s;
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        dout_n  = b;
                        ferr_n  = ~rx_s;
                        done_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_n  = ^{b, par};
`endif
                        // A low stop sample means break: wait for idle.
                        state_n = rx_s ? IDLE : BRK;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver with its own baud-tick generator.
- Converts the serial rx line into parallel DBIT-bit words.
- Sits directly upstream of the receive FIFO in the loopback UART test design. rx_done_tick drives the FIFO write strobe; dout drives the FIFO write data.
- Detects false starts and framing errors. Holds off after a break until the line returns idle.

Parameters:
- DBIT, 8: data bits per frame, LSB first.
- SB_TICK, 16: oversample ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR, 163: clock cycles per oversample tick, i.e. clk / (16 * baud). 163 gives 19200 baud at 50 MHz. DVSR = 1 means a tick every cycle.
- DVSR_BIT, 8: width of the baud counter. Must satisfy 2^DVSR_BIT >= DVSR.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-low reset.
- rx, input, 1: asynchronous serial line, idle high.
- rx_done_tick, output, 1: one-cycle pulse when a frame completes. dout and frame_err are valid in the same cycle.
- dout, output, DBIT: last received word, held until the next frame completes.
- frame_err, output, 1: stop sample of the last completed frame was 0. Updated only on rx_done_tick.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE; s = 0; n = 0; shift register b = 0; baud counter = 0.
  - Synchronizer stages = 1.
  - Outputs: rx_done_tick = 0, dout = 0, frame_err = 0, busy = 0.
  - Reset mid-frame aborts the frame; no done pulse is produced.
- Synchronizer: two flops on rx produce rx_s, giving 2 cycles of latency. All decisions use rx_s only.
- Baud generator:
  - Counter counts 0..DVSR-1 and wraps.
  - s_tick = 1 in the cycle the counter equals DVSR-1.
  - For DVSR = 1, s_tick is constantly 1.
  - Free-running; not re-phased on the start edge, so sampling jitter is at most 1/16 bit.
- State machine (s counts ticks, n counts bits):
  - IDLE: rx_s == 0 -> START, s = 0. Ticks are ignored.
  - START: on s_tick:
    - s == 7 and rx_s == 0 -> DATA, s = 0, n = 0.
    - s == 7 and rx_s == 1 -> IDLE (false start, no output).
    - otherwise s++.
  - DATA: on s_tick:
    - s == 15 -> b = {rx_s, b[DBIT-1:1]}, s = 0. If n == DBIT-1 -> STOP, else n++.
    - otherwise s++.
  - STOP: on s_tick with s == SB_TICK-1:
    - Register dout = b and frame_err = ~rx_s, and pulse rx_done_tick in the following cycle.
    - rx_s == 1 -> IDLE; rx_s == 0 -> BRK.
    - otherwise s++.
  - BRK: stays until rx_s == 1, then -> IDLE. A held-low line yields exactly one frame_err frame, not repeated frames.
- A new falling edge arriving while in STOP is not detected until IDLE is reached. Back-to-back frames with a full stop bit must be received without loss.
- rx_done_tick is never asserted two cycles in a row. The downstream FIFO is write-only from this block; there is no backpressure, and an overflow is the FIFO's concern.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP. It samples one bit at s == 15 and checks even parity over data plus parity bit.
  - Adds output parity_err (1 bit), registered on rx_done_tick and reset to 0.
  - Frame length becomes 1 + DBIT + 1 + stop.
- Undefined: no PARITY state and no parity_err port. Behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - state encoding enum: IDLE, START, DATA, PARITY, STOP, BRK;
  - constants OS_TICKS = 16 and MID_TICK = 7.
  - Shared with the tx side.
- Sub-module uart_baud_gen holds the mod-DVSR counter (parameters DVSR, DVSR_BIT; outputs s_tick and the count). It is reused by the transmitter.

Test Plan:
- Reset: hold reset = 0 for 3 clk with rx toggling -> all outputs 0, busy = 0. Release -> busy stays 0 while rx = 1.
- Nominal frame, DVSR = 1: send 0xA5 (LSB first, 16 clk/bit, 1 stop) -> single rx_done_tick 152–156 clk after the rx falling edge, dout = 0xA5, frame_err = 0, busy = 0 the cycle after.
- Back-to-back: 0x00, 0xFF, 0x3C with no idle gap -> three done pulses, dout in order 0x00, 0xFF, 0x3C, frame_err = 0 on each.
- False start: 4-clk low glitch on rx -> no rx_done_tick; busy returns to 0 within 12 clk.
- Framing error/break: send 0x55 with stop bit 0, then hold rx low for 1000 clk -> exactly one done pulse with dout = 0x55 and frame_err = 1; busy stays 1 until rx rises. The next valid 0x12 is received with frame_err = 0.
- Reset mid-frame: assert reset during data bit 4 of 0x81 -> no done pulse. The next full frame 0x81 is received correctly.
